// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared state codes and strobe constants for the RV32I control sequencer
package cpu_sequencer_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_TGT = 1'b1;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_DECODE = 3'd2,
    SEQ_EXEC   = 3'd3,
    SEQ_MEM    = 3'd4,
    SEQ_WB     = 3'd5,
    SEQ_HALT   = 3'd6,
    SEQ_FAULT  = 3'd7
  } seq_state_e;

endpackage

// File: rtl/cpu_sequencer_mem_timeout.sv
// rtl/cpu_sequencer_mem_timeout.sv - req/ack wait watchdog; flags the last allowed wait cycle
module cpu_sequencer_mem_timeout #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  input  logic clear,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;
  logic            waiting;

  assign waiting = req & ~ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (waiting) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  // An ack in the final cycle masks expiry because waiting already excludes it.
  assign expired = (TIMEOUT != 0) && waiting && (cnt == LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with perf counters
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             reg_we,
  input  logic             is_jump,
  input  logic             halt_insn,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  seq_state_e cur, nxt;
  logic       l_load, l_store, l_reg_we, l_jump, l_halt;
  logic       imem_exp, dmem_exp;
  logic       active;

  assign state  = cur;
  assign active = (cur == SEQ_FETCH) || (cur == SEQ_DECODE) || (cur == SEQ_EXEC) ||
                  (cur == SEQ_MEM)   || (cur == SEQ_WB);

  // Counters sit at zero outside their phase, so each FETCH/MEM visit starts fresh.
  cpu_sequencer_mem_timeout #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_imem_to (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (imem_req),
    .ack     (imem_ack),
    .clear   (cur != SEQ_FETCH),
    .expired (imem_exp)
  );

  cpu_sequencer_mem_timeout #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_dmem_to (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (dmem_req),
    .ack     (dmem_ack),
    .clear   (cur != SEQ_MEM),
    .expired (dmem_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= SEQ_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_load   <= 1'b0;
      l_store  <= 1'b0;
      l_reg_we <= 1'b0;
      l_jump   <= 1'b0;
      l_halt   <= 1'b0;
    end else if (cur == SEQ_DECODE) begin
      l_load   <= is_load;
      l_store  <= is_store;
      l_reg_we <= reg_we;
      l_jump   <= is_jump;
      l_halt   <= halt_insn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (active) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (cur == SEQ_WB) begin
        instret_cnt <= instret_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    nxt      = cur;
    imem_req = DISABLE;
    dmem_req = DISABLE;
    dmem_we  = DISABLE;
    ir_we    = DISABLE;
    rf_we    = DISABLE;
    pc_we    = DISABLE;
    pc_sel   = PC_SEL_SEQ;
    halted   = DISABLE;
    fault    = DISABLE;
    case (cur)
      SEQ_IDLE: begin
        if (start) nxt = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        imem_req = ENABLE;
        if (imem_ack) begin
          ir_we = ENABLE;
          nxt   = SEQ_DECODE;
        end else if (imem_exp) begin
          nxt = SEQ_FAULT;
        end
      end
      SEQ_DECODE: nxt = SEQ_EXEC;
      SEQ_EXEC: begin
        if (l_halt)                 nxt = SEQ_HALT;
        else if (l_load || l_store) nxt = SEQ_MEM;
        else                        nxt = SEQ_WB;
      end
      SEQ_MEM: begin
        // A load+store decode is treated as a store.
        dmem_req = ENABLE;
        dmem_we  = l_store;
        if (dmem_ack)      nxt = SEQ_WB;
        else if (dmem_exp) nxt = SEQ_FAULT;
      end
      SEQ_WB: begin
        rf_we  = l_reg_we;
        pc_we  = ENABLE;
        pc_sel = l_jump ? PC_SEL_TGT : PC_SEL_SEQ;
        nxt    = pause ? SEQ_IDLE : SEQ_FETCH;
      end
      SEQ_HALT:  halted = ENABLE;
      SEQ_FAULT: fault  = ENABLE;
      default:   nxt    = SEQ_FAULT;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized instruction-level checks of cpu_sequencer against a phase model
module tb_cpu_sequencer;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, pause;
  logic             is_load, is_store, reg_we, is_jump, halt_insn;
  logic             imem_ack, dmem_ack;
  logic             imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel;
  logic [2:0]       state;
  logic             halted, fault;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int m_cycle = 0;
  int m_instret = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pause       (pause),
    .is_load     (is_load),
    .is_store    (is_store),
    .reg_we      (reg_we),
    .is_jump     (is_jump),
    .halt_insn   (halt_insn),
    .imem_ack    (imem_ack),
    .dmem_ack    (dmem_ack),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .ir_we       (ir_we),
    .rf_we       (rf_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .state       (state),
    .halted      (halted),
    .fault       (fault),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  wire [8:0] obs = {imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel, halted, fault};

  function automatic logic [8:0] vec(input bit ireq, input bit dreq, input bit dwe, input bit irw,
                                     input bit rfw, input bit pcw, input bit pcs, input bit hlt,
                                     input bit flt);
    return {ireq, dreq, dwe, irw, rfw, pcw, pcs, hlt, flt};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle(input string tag, input int st, input logic [8:0] ev);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_out"}, 32'(obs), 32'(ev));
    check({tag, "_cycle"}, 32'(cycle_cnt), 32'(m_cycle % (1 << CNT_W)));
    check({tag, "_instret"}, 32'(instret_cnt), 32'(m_instret % (1 << CNT_W)));
  endtask

  task automatic rand_acks();
    imem_ack = 1'($urandom_range(0, 1));
    dmem_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic scramble_flags();
    is_load   = 1'($urandom_range(0, 1));
    is_store  = 1'($urandom_range(0, 1));
    reg_we    = 1'($urandom_range(0, 1));
    is_jump   = 1'($urandom_range(0, 1));
    halt_insn = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_cycle   = 0;
    m_instret = 0;
    check_cycle("reset", 0, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
  endtask

  task automatic dead_tail(input string tag, input int st, input logic [8:0] ev);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      pause = 1'($urandom_range(0, 1));
      rand_acks();
      #1;
      check_cycle(tag, st, ev);
    end
  endtask

  // outcome: 0 next FETCH, 1 paused to IDLE, 2 halted, 3 faulted, 4 reset aborted
  task automatic run_insn(output int outcome);
    bit ld, sto, rw, jp, ht, pz;
    int fw, mw;
    ld  = ($urandom_range(0, 2) == 0);
    sto = ($urandom_range(0, 2) == 0);
    rw  = 1'($urandom_range(0, 1));
    jp  = ($urandom_range(0, 3) == 0);
    ht  = ($urandom_range(0, 11) == 0);
    pz  = ($urandom_range(0, 3) == 0);
    fw  = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
    mw  = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
    outcome = 0;

    for (int k = 0; k <= fw; k++) begin
      @(negedge clk);
      start = 1'b0; pause = 1'b0;
      is_load = ld; is_store = sto; reg_we = rw; is_jump = jp; halt_insn = ht;
      imem_ack = (k == fw);
      dmem_ack = 1'($urandom_range(0, 1));
      #1;
      check_cycle("fetch", 1, vec(1, 0, 0, (k == fw), 0, 0, 0, 0, 0));
      m_cycle++;
      if (k != fw && k == TIMEOUT - 1) begin
        dead_tail("fetch_fault", 7, vec(0, 0, 0, 0, 0, 0, 0, 0, 1));
        outcome = 3;
        return;
      end
    end

    @(negedge clk);
    rand_acks();
    #1;
    check_cycle("decode", 2, 9'd0);
    m_cycle++;

    @(negedge clk);
    scramble_flags();
    rand_acks();
    #1;
    check_cycle("exec", 3, 9'd0);
    m_cycle++;

    if (ht) begin
      dead_tail("halt", 6, vec(0, 0, 0, 0, 0, 0, 0, 1, 0));
      outcome = 2;
      return;
    end

    if (ld || sto) begin
      for (int k = 0; k <= mw; k++) begin
        @(negedge clk);
        scramble_flags();
        dmem_ack = (k == mw);
        imem_ack = 1'($urandom_range(0, 1));
        #1;
        check_cycle("mem", 4, vec(0, 1, sto, 0, 0, 0, 0, 0, 0));
        m_cycle++;
        if (k != mw && k == TIMEOUT - 1) begin
          dead_tail("mem_fault", 7, vec(0, 0, 0, 0, 0, 0, 0, 0, 1));
          outcome = 3;
          return;
        end
        if (k != mw && $urandom_range(0, 7) == 0) begin
          rst_n = 1'b0;
          #1;
          m_cycle   = 0;
          m_instret = 0;
          check_cycle("mem_abort", 0, 9'd0);
          @(negedge clk);
          rst_n = 1'b1;
          outcome = 4;
          return;
        end
      end
    end

    @(negedge clk);
    scramble_flags();
    pause = pz;
    rand_acks();
    #1;
    check_cycle("wb", 5, vec(0, 0, 0, 0, rw, 1, jp, 0, 0));
    m_cycle++;
    m_instret++;
    outcome = pz ? 1 : 0;
  endtask

  initial begin
    int outcome;
    int n_insn;
    rst_n = 1'b0;
    start = 1'b0; pause = 1'b0;
    is_load = 1'b0; is_store = 1'b0; reg_we = 1'b0; is_jump = 1'b0; halt_insn = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_cycle("por", 0, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int ep = 0; ep < 60; ep++) begin
      @(negedge clk);
      start = 1'b0; pause = 1'($urandom_range(0, 1));
      rand_acks();
      #1;
      check_cycle("idle_hold", 0, 9'd0);

      @(negedge clk);
      start = 1'b1; pause = 1'b0;
      rand_acks();
      #1;
      check_cycle("idle_start", 0, 9'd0);

      outcome = 0;
      n_insn  = 0;
      while (outcome == 0 && n_insn < 12) begin
        run_insn(outcome);
        n_insn++;
      end
      if (outcome == 0 || outcome == 2 || outcome == 3) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
